// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch predictor with 2-bit counters and mispredict flush
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        f_valid,
    input  logic [63:0] f_pc,
    output logic        pred_taken,
    output logic [63:0] pred_target,
    input  logic        u_valid,
    input  logic        u_is_branch,
    input  logic [63:0] u_pc,
    input  logic        u_taken,
    input  logic [63:0] u_target,
    input  logic        u_pred_taken,
    input  logic [63:0] u_pred_target,
    output logic        mispredict,
    output logic [63:0] redirect_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic             tbl_valid  [ENTRIES];
    logic [TAG_W-1:0] tbl_tag    [ENTRIES];
    logic [63:0]      tbl_target [ENTRIES];
    logic [1:0]       tbl_ctr    [ENTRIES];

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             upd_en;
    logic             mis_cond;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[IDX_W+2 +: TAG_W];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[IDX_W+2 +: TAG_W];

    // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet
    always_comb begin
        f_hit       = tbl_valid[f_idx] && (tbl_tag[f_idx] == f_tag);
        pred_taken  = f_valid && f_hit && tbl_ctr[f_idx][1];
        pred_target = pred_taken ? tbl_target[f_idx] : f_pc + 64'd4;
    end

    // Update qualification and mispredict detection from the execute-stage result
    always_comb begin
        upd_en   = u_valid && u_is_branch;
        u_hit    = tbl_valid[u_idx] && (tbl_tag[u_idx] == u_tag);
        mis_cond = upd_en && ((u_taken != u_pred_taken) ||
                              (u_taken && (u_target != u_pred_target)));
    end

    // Valid bits and counters: train on hits, allocate weakly-taken on taken misses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_ctr[i]   <= 2'b01;
            end
        end else if (upd_en) begin
            if (u_hit) begin
                if (u_taken && tbl_ctr[u_idx] != 2'b11)
                    tbl_ctr[u_idx] <= tbl_ctr[u_idx] + 2'd1;
                else if (!u_taken && tbl_ctr[u_idx] != 2'b00)
                    tbl_ctr[u_idx] <= tbl_ctr[u_idx] - 2'd1;
            end else if (u_taken) begin
                tbl_valid[u_idx] <= 1'b1;
                tbl_ctr[u_idx]   <= 2'b10;
            end
        end
    end

    // Tags and targets carry no reset; a taken update either refreshes or allocates them
    always_ff @(posedge clk) begin
        if (upd_en && u_taken) begin
            tbl_tag[u_idx]    <= u_tag;
            tbl_target[u_idx] <= u_target;
        end
    end

    // Registered flush pulse, redirect PC and saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            redirect_pc      <= 64'd0;
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            mispredict <= mis_cond;
            if (upd_en) begin
                redirect_pc <= u_taken ? u_target : u_pc + 64'd4;
                if (branch_count != 32'hFFFF_FFFF)
                    branch_count <= branch_count + 32'd1;
            end
            if (mis_cond && mispredict_count != 32'hFFFF_FFFF)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard testbench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid = 1'b0;
    logic [63:0] f_pc = 64'd0;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        u_valid = 1'b0;
    logic        u_is_branch = 1'b0;
    logic [63:0] u_pc = 64'd0;
    logic        u_taken = 1'b0;
    logic [63:0] u_target = 64'd0;
    logic        u_pred_taken = 1'b0;
    logic [63:0] u_pred_target = 64'd0;
    logic        mispredict;
    logic [63:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    branch_predictor #(.ENTRIES(16), .TAG_W(10)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .f_valid          (f_valid),
        .f_pc             (f_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .u_valid          (u_valid),
        .u_is_branch      (u_is_branch),
        .u_pc             (u_pc),
        .u_taken          (u_taken),
        .u_target         (u_target),
        .u_pred_taken     (u_pred_taken),
        .u_pred_target    (u_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [63:0] target;
    } lk_exp_t;

    typedef struct {
        logic        mis;
        logic [63:0] redir;
        logic [31:0] bc;
        logic [31:0] mc;
    } up_exp_t;

    lk_exp_t lk_q[$];
    up_exp_t up_q[$];
    int      checks = 0;
    int      errors = 0;
    logic    upd_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Remember that an update was presented so its registered result is checked next cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) upd_seen <= 1'b0;
        else        upd_seen <= u_valid;
    end

    // Monitor: pop expected lookup/update results and compare away from the clock edge
    always @(negedge clk) begin
        if (rst_n && f_valid) begin
            if (lk_q.size() == 0) begin
                chk("lookup_q_underflow", 64'd1, 64'd0);
            end else begin
                lk_exp_t e;
                e = lk_q.pop_front();
                chk("pred_taken", {63'd0, pred_taken}, {63'd0, e.taken});
                chk("pred_target", pred_target, e.target);
            end
        end
        if (upd_seen) begin
            if (up_q.size() == 0) begin
                chk("update_q_underflow", 64'd1, 64'd0);
            end else begin
                up_exp_t e;
                e = up_q.pop_front();
                chk("mispredict", {63'd0, mispredict}, {63'd0, e.mis});
                chk("redirect_pc", redirect_pc, e.redir);
                chk("branch_count", {32'd0, branch_count}, {32'd0, e.bc});
                chk("mispredict_count", {32'd0, mispredict_count}, {32'd0, e.mc});
            end
        end
    end

    task automatic lookup(input logic [63:0] pc, input logic et, input logic [63:0] etg);
        lk_exp_t e;
        f_valid = 1'b1;
        f_pc    = pc;
        e.taken = et;
        e.target = etg;
        lk_q.push_back(e);
    endtask

    task automatic update(input logic br, input logic [63:0] pc, input logic tk,
                          input logic [63:0] tg, input logic ptk, input logic [63:0] ptg,
                          input logic emis, input logic [63:0] eredir,
                          input logic [31:0] ebc, input logic [31:0] emc);
        up_exp_t e;
        u_valid       = 1'b1;
        u_is_branch   = br;
        u_pc          = pc;
        u_taken       = tk;
        u_target      = tg;
        u_pred_taken  = ptk;
        u_pred_target = ptg;
        e.mis = emis;
        e.redir = eredir;
        e.bc = ebc;
        e.mc = emc;
        up_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        f_valid = 1'b0;
        u_valid = 1'b0;
        u_is_branch = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_mispredict", {63'd0, mispredict}, 64'd0);
        chk("reset_redirect", redirect_pc, 64'd0);
        chk("reset_branch_count", {32'd0, branch_count}, 64'd0);
        chk("reset_mis_count", {32'd0, mispredict_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        lookup(64'h1000, 1'b0, 64'h1004); tick();
        update(1, 64'h1000, 1, 64'h0F00, 0, 64'h0, 1, 64'h0F00, 1, 1); tick();
        lookup(64'h1000, 1'b1, 64'h0F00); tick();
        update(1, 64'h1000, 1, 64'h0F00, 1, 64'h0F00, 0, 64'h0F00, 2, 1); tick();
        update(0, 64'h1000, 0, 64'h0, 1, 64'h0F00, 0, 64'h0F00, 2, 1); tick();
        update(1, 64'h1000, 0, 64'h0, 1, 64'h0F00, 1, 64'h1004, 3, 2); tick();
        update(1, 64'h1000, 0, 64'h0, 1, 64'h0F00, 1, 64'h1004, 4, 3); tick();
        lookup(64'h1000, 1'b0, 64'h1004);
        update(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h1004, 5, 3); tick();
        update(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h1004, 6, 3); tick();
        lookup(64'h1000, 1'b0, 64'h1004);
        update(1, 64'h1000, 0, 64'h0, 0, 64'h0, 0, 64'h1004, 7, 3); tick();
        lookup(64'h1000, 1'b0, 64'h1004);
        update(1, 64'h1000, 1, 64'h0F00, 0, 64'h0, 1, 64'h0F00, 8, 4); tick();
        lookup(64'h1000, 1'b0, 64'h1004); tick();
        update(1, 64'h1040, 1, 64'h2000, 0, 64'h0, 1, 64'h2000, 9, 5); tick();
        lookup(64'h1000, 1'b0, 64'h1004); tick();
        lookup(64'h1040, 1'b1, 64'h2000);
        update(1, 64'h1040, 1, 64'h3000, 1, 64'h2000, 1, 64'h3000, 10, 6); tick();
        lookup(64'h1040, 1'b1, 64'h3000);
        update(1, 64'h1080, 0, 64'h0, 0, 64'h0, 0, 64'h1084, 11, 6); tick();
        lookup(64'h1040, 1'b1, 64'h3000); tick();
        lookup(64'h2008, 1'b0, 64'h200C);
        update(1, 64'h2008, 1, 64'h4000, 0, 64'h0, 1, 64'h4000, 12, 7); tick();
        lookup(64'h2008, 1'b1, 64'h4000); tick();

        u_valid = 1'b1; u_is_branch = 1'b1; u_pc = 64'h3000; u_taken = 1'b1;
        u_target = 64'h10; u_pred_taken = 1'b0; u_pred_target = 64'h0;
        tick();
        chk("pending_pulse", {63'd0, mispredict}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mispredict", {63'd0, mispredict}, 64'd0);
        chk("abort_redirect", redirect_pc, 64'd0);
        chk("abort_branch_count", {32'd0, branch_count}, 64'd0);
        chk("abort_mis_count", {32'd0, mispredict_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lookup(64'h2008, 1'b0, 64'h200C);
        update(1, 64'h2008, 0, 64'h0, 0, 64'h0, 0, 64'h200C, 1, 0); tick();
        lookup(64'h2008, 1'b0, 64'h200C); tick();
        tick();
        tick();

        chk("lookup_q_empty", 64'(lk_q.size()), 64'd0);
        chk("update_q_empty", 64'(up_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16: number of direct-mapped table entries (power of two, 4 to 64).
REQ-002 SHALL have parameter TAG_W, default 10: stored tag width, taken from pc[log2(ENTRIES)+2 +: TAG_W].
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port f_valid  input  1  a fetch lookup is requested this cycle.
REQ-006 SHALL have port f_pc  input  64  the PC being fetched.
REQ-007 SHALL have port pred_taken  output  1  prediction for f_pc (combinational).
REQ-008 SHALL have port pred_target  output  64  predicted next PC for f_pc (combinational).
REQ-009 SHALL have port u_valid  input  1  a resolved instruction is presented from execute.
REQ-010 SHALL have port u_is_branch  input  1  the resolved instruction is B-type (format 3'b011).
REQ-011 SHALL have port u_pc  input  64  PC of the resolved instruction.
REQ-012 SHALL have port u_taken  input  1  resolved branch_taken.
REQ-013 SHALL have port u_target  input  64  resolved branch_target.
REQ-014 SHALL have port u_pred_taken  input  1  prediction made for this instruction at fetch, carried down the pipeline.
REQ-015 SHALL have port u_pred_target  input  64  predicted target carried down the pipeline.
REQ-016 SHALL have port mispredict  output  1  registered one-cycle flush pulse.
REQ-017 SHALL have port redirect_pc  output  64  registered correct next PC, valid when mispredict=1.
REQ-018 SHALL have port branch_count  output  32  resolved branches counted since reset.
REQ-019 SHALL have port mispredict_count  output  32  mispredictions counted since reset.

Function
REQ-020 SHALL compute index = pc[log2(ENTRIES)+1:2]; each entry holds a valid bit, a TAG_W tag, a 64-bit target and a 2-bit saturating counter.
REQ-021 SHALL compute a lookup hit as valid[idx] and tag equal to the f_pc tag bits.
REQ-022 SHALL drive pred_taken = f_valid and hit and counter[1]; SHALL drive pred_target = stored target when pred_taken=1, else f_pc+4 (modulo 2^64).
REQ-023 SHALL perform an update on a clock edge with u_valid=1 and u_is_branch=1; u_valid=1 with u_is_branch=0 SHALL change no table entry, counter or output.
REQ-024 On an update hit, the counter SHALL increment saturating at 2'b11 if u_taken=1 and decrement saturating at 2'b00 if u_taken=0, and SHALL write target=u_target when u_taken=1.
REQ-025 On an update miss with u_taken=1, SHALL allocate the entry: valid=1, tag from u_pc, target=u_target, counter=2'b10, overwriting any previous occupant.
REQ-026 On an update miss with u_taken=0, SHALL leave the table unchanged.
REQ-027 A lookup and an update in the same cycle (same or different index) SHALL see pre-update table state; the update becomes visible on the next cycle.
REQ-028 The mispredict condition SHALL be: u_valid, u_is_branch, and (u_taken != u_pred_taken, or u_taken=1 and u_target != u_pred_target).
REQ-029 mispredict SHALL be registered: asserted exactly in the cycle after the condition holds, for one cycle per qualifying update; back-to-back updates SHALL yield back-to-back pulses.
REQ-030 redirect_pc SHALL be registered on every branch update as u_taken ? u_target : u_pc+4, and SHALL hold its value otherwise.
REQ-031 branch_count SHALL increment by 1 per branch update; mispredict_count SHALL increment by 1 per mispredict condition; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 No output SHALL depend on u_* inputs combinationally.

Reset
REQ-033 While rst_n=0, asynchronously: all valid bits=0, all counters=2'b01, mispredict=0, redirect_pc=0, branch_count=0, mispredict_count=0; tags and targets need not be reset.
REQ-034 After reset, every lookup SHALL miss: pred_taken=0 and pred_target=f_pc+4.
REQ-035 Reset asserted mid-operation SHALL abort any pending mispredict pulse; the first update after release SHALL behave as if the table were empty.

Verification
REQ-036 Post-reset lookup f_pc=0x1000 -> pred_taken=0, pred_target=0x1004, counters both 0.
REQ-037 Update u_pc=0x1000, taken, u_target=0x0F00, pred_taken=0 -> next cycle mispredict=1, redirect_pc=0x0F00, mispredict_count=1; then lookup 0x1000 -> pred_taken=1, pred_target=0x0F00.
REQ-038 Four not-taken updates on 0x1000 -> counter reaches 2'b00 (saturates), lookup pred_taken=0; a fifth not-taken update SHALL keep 2'b00.
REQ-039 Alias: allocate 0x1000 (taken), then taken update at 0x1000+4*ENTRIES with target 0x2000 -> entry replaced; lookup 0x1000 misses, lookup of the new PC predicts 0x2000.
REQ-040 Correct prediction (u_taken=1, u_pred_taken=1, matching targets) -> mispredict stays 0, branch_count increments; u_valid=1 with u_is_branch=0 -> no count change, no pulse.
REQ-041 Same-cycle lookup and allocating update of the same PC -> lookup returns miss this cycle and hit the next cycle; rst_n pulsed during a pending pulse -> mispredict=0 and counters=0.
